// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle between a counter user (master) and mod_counter (slave)
interface mod_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              up_dn_n;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              ovf_clr;
    logic [WIDTH-1:0]  cmp_val;
    logic [WIDTH-1:0]  cnt;
    logic              tc;
    logic              ovf;
    logic              cmp_hit;

    modport master (
        output en, up_dn_n, step, sat_mode, load, load_val, ovf_clr, cmp_val,
        input  cnt, tc, ovf, cmp_hit
    );

    modport slave (
        input  en, up_dn_n, step, sat_mode, load, load_val, ovf_clr, cmp_val,
        output cnt, tc, ovf, cmp_hit
    );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo MAX_VAL+1 up/down counter with step, load, wrap/saturate, tc pulse and sticky ovf; MOD_COUNTER_CMP_EN adds a registered compare match
module mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP_W  = 4
) (
    input  logic         clk50m,
    input  logic         rst,
    mod_counter_if.slave bus
);
    localparam int AW = (WIDTH > STEP_W ? WIDTH : STEP_W) + 1;
    localparam logic [AW-1:0] MV  = AW'(MAX_VAL);
    localparam logic [AW-1:0] MOD = AW'(MAX_VAL + 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    c, s, sum, nxt, ld;
    logic             up_ev, dn_ev, ev;

    // Next count: clamp step and load value, detect boundary crossing, then wrap or saturate
    always_comb begin
        c     = AW'(cnt_q);
        s     = AW'(bus.step) > MV ? MV : AW'(bus.step);
        ld    = AW'(bus.load_val) > MV ? MV : AW'(bus.load_val);
        sum   = c + s;
        up_ev = sum > MV;
        dn_ev = s > c;
        ev    = bus.en && !bus.load && (bus.up_dn_n ? up_ev : dn_ev);
        nxt   = bus.up_dn_n ? (up_ev ? (bus.sat_mode ? MV : sum - MOD) : sum)
                            : (dn_ev ? (bus.sat_mode ? '0 : c + MOD - s) : c - s);
        cnt_d = bus.load ? WIDTH'(ld) : bus.en ? WIDTH'(nxt) : cnt_q;
        tc_d  = ev;
        ovf_d = ev || (ovf_q && !bus.ovf_clr);
    end

    // State registers; reset overrides load, enable and flag clear
    always_ff @(posedge clk50m) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.cnt = cnt_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;

`ifdef MOD_COUNTER_CMP_EN
    logic [AW-1:0] cmp_t;
    logic          cmp_hit_q;

    assign cmp_t = AW'(bus.cmp_val) > MV ? MV : AW'(bus.cmp_val);

    // Compare match registered one cycle after the count shows the clamped compare value
    always_ff @(posedge clk50m) begin
        if (rst) cmp_hit_q <= 1'b0;
        else     cmp_hit_q <= (AW'(cnt_q) == cmp_t);
    end

    assign bus.cmp_hit = cmp_hit_q;
`else
    logic unused_cmp;
    assign unused_cmp  = ^bus.cmp_val;
    assign bus.cmp_hit = 1'b0;
`endif
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised up/down counter, next generation of the team's basic up/down counter.
- Adds a programmable modulus (MAX_VAL), runtime step size, parallel load, and a wrap/saturate mode.
- Provides a registered terminal-count pulse and a sticky overflow flag.
- Used as a timebase, address and event counter inside the clk50m domain.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VAL, 2**WIDTH-1, highest count value. Legal range 1 .. 2**WIDTH-1. Count range is 0..MAX_VAL, modulus MAX_VAL+1.
- STEP_W, 4, width of the step input.

Ports:
- clk50m  in  1  50 MHz system clock; all logic on rising edge.
- rst  in  1  reset.
- en  in  1  1 = perform one count operation this cycle.
- up_dn_n  in  1  1 = up, 0 = down.
- step  in  STEP_W  increment/decrement amount per enabled cycle.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
- load  in  1  1 = load load_val this cycle.
- load_val  in  WIDTH  value to load.
- ovf_clr  in  1  clears the sticky ovf flag.
- cmp_val  in  WIDTH  compare value (optional feature only).
- cnt  out  WIDTH  registered count.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky overflow/underflow flag.
- cmp_hit  out  1  registered compare match (optional feature only).

Interface decision:
- One clock; reset is synchronous and active-high.

Behaviour:
- Reset:
  - rst=1 at a clk50m edge gives cnt=0, tc=0, ovf=0, cmp_hit=0.
  - rst overrides load, en and ovf_clr in the same cycle.
- Priority per cycle: rst > load > en. With en=0 and load=0, cnt holds and tc=0.
- Load:
  - cnt <= min(load_val, MAX_VAL) with 1-cycle latency.
  - tc=0 that cycle; ovf is unaffected.
- Effective step:
  - s = min(step, MAX_VAL).
  - s=0 with en=1 holds cnt, tc=0, and is not an event.
- Arithmetic:
  - Computed at WIDTH+1 bits internally; no intermediate truncation.
  - Up: n = cnt + s. If n > MAX_VAL it is a boundary event.
  - Down: if s > cnt it is a boundary event; otherwise n = cnt - s.
- Wrap mode (sat_mode=0):
  - Up event: cnt <= cnt + s - (MAX_VAL+1).
  - Down event: cnt <= cnt + (MAX_VAL+1) - s.
- Saturate mode (sat_mode=1):
  - Up event: cnt <= MAX_VAL.
  - Down event: cnt <= 0.
  - An enabled step that would leave the range again while already at the bound is again an event.
- No event: cnt <= n.
- tc:
  - Registered together with cnt. tc=1 for exactly the cycle in which cnt shows the result of a boundary event, otherwise 0.
  - Landing exactly on MAX_VAL or 0 without crossing is not an event.
- ovf:
  - Set on any boundary event.
  - Cleared by ovf_clr when no event occurs in the same cycle; a simultaneous event wins (ovf stays 1).
- Mode switching: sat_mode, up_dn_n and step are sampled each cycle; changes take effect immediately with no pipeline.

Optional Feature:
- Macro: MOD_COUNTER_CMP_EN.
- Defined:
  - cmp_hit is registered and equals 1 in the cycle after the registered cnt equals min(cmp_val, MAX_VAL).
  - Reset drives cmp_hit to 0.
  - cmp_hit stays 1 while equality holds.
- Undefined:
  - cmp_hit is tied to 0 and cmp_val is ignored. Ports remain present so instantiations do not change.

Test Plan:
All scenarios use WIDTH=4, MAX_VAL=9, STEP_W=4.
1. Reset: hold rst=1 for 2 cycles with en=1, load=1, load_val=5 -> cnt=0, tc=0, ovf=0, cmp_hit=0.
2. Wrap up/down (sat_mode=0):
   - Load 8, then en=1, up, step=3 -> cnt=1, tc=1 for one cycle, ovf=1.
   - Next cycle down, step=2 -> cnt=9, tc=1.
   - Next cycle down, step=9 -> cnt=0, tc=0.
3. Saturate (sat_mode=1):
   - Load 7, up, step=5 -> cnt=9, tc=1.
   - Repeat -> cnt=9, tc=1.
   - Down, step=15 (clamped to 9) -> cnt=0, tc=0.
   - Down, step=1 -> cnt=0, tc=1.
4. Load priority/clamp:
   - load=1, load_val=12, en=1 -> cnt=9, tc=0.
   - Then rst=1 with load=1 -> cnt=0.
5. Sticky flag:
   - With ovf=1, assert ovf_clr together with a wrap event -> ovf stays 1.
   - Next cycle ovf_clr alone -> ovf=0.
   - en=1 with step=0 -> cnt unchanged, tc=0.
6. With MOD_COUNTER_CMP_EN defined, cmp_val=4:
   - Count up by 1 from 0 -> cmp_hit=1 in the cycle after cnt=4, 0 again after cnt=5.
   - Without the macro -> cmp_hit always 0.
